// File: rtl/fp16_add_sequencer_if.sv
// Handshake and shifter bundle for the fp16 add/subtract sequencer.
// The slave side is the sequencer; the master side is requester plus shifter.
interface fp16_add_sequencer_if #(
    parameter int WIDTH        = 16,
    parameter int AMOUNT_WIDTH = 8
);
    logic                    start_in;
    logic [15:0]             a_in;
    logic [15:0]             b_in;
    logic                    op_in;
    logic                    busy_out;
    logic                    done_out;
    logic [15:0]             result_out;
    logic [WIDTH-1:0]        shift_data_out;
    logic [AMOUNT_WIDTH-1:0] shift_amount_out;
    logic                    shift_dir_out;
    logic [WIDTH-1:0]        shift_data_in;

    modport master (
        output start_in, a_in, b_in, op_in, shift_data_in,
        input  busy_out, done_out, result_out,
        input  shift_data_out, shift_amount_out, shift_dir_out
    );

    modport slave (
        input  start_in, a_in, b_in, op_in, shift_data_in,
        output busy_out, done_out, result_out,
        output shift_data_out, shift_amount_out, shift_dir_out
    );
endinterface

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle binary16 add/subtract controller sharing one external shifter.
// Subnormals flush to zero; rounding is by truncation.
module fp16_add_sequencer #(
    parameter int WIDTH        = 16,
    parameter int AMOUNT_WIDTH = 8
) (
    input logic                clock_in,
    input logic                reset_in,
    fp16_add_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, DONE
    } state_t;

    state_t state, state_d;

    logic [15:0] a_q, b_q;
    logic        l_sign, eff_sub;
    logic [4:0]  l_exp, diff;
    logic [15:0] l_sig, m_sig, m_al, sum_q;
    logic [15:0] result_q;

    // unpack decode
    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic        sa, sb;
    logic        a_z, b_z, a_i, b_i, a_n, b_n;
    logic        a_ge;
    logic        spec_hit;
    logic [15:0] spec_res;

    // add / normalize
    logic [15:0]       sum_d;
    logic [3:0]        lzc;
    logic signed [6:0] exp_n;
    logic [15:0]       norm_res;
    logic [15:0]       res_d;

    assign ea = a_q[14:10];
    assign eb = b_q[14:10];
    assign fa = a_q[9:0];
    assign fb = b_q[9:0];
    assign sa = a_q[15];
    assign sb = b_q[15];

    assign a_z  = (ea == 5'd0);
    assign b_z  = (eb == 5'd0);
    assign a_i  = (&ea) && (fa == 10'd0);
    assign b_i  = (&eb) && (fb == 10'd0);
    assign a_n  = (&ea) && (fa != 10'd0);
    assign b_n  = (&eb) && (fb != 10'd0);
    assign a_ge = (a_q[14:0] >= b_q[14:0]);

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 16'h0000;
        if (a_n || b_n)
            spec_res = 16'h7E00;
        else if (a_i && b_i)
            spec_res = (sa != sb) ? 16'h7E00 : a_q;
        else if (a_i)
            spec_res = a_q;
        else if (b_i)
            spec_res = b_q;
        else if (a_z && b_z)
            spec_res = 16'h0000;
        else if (a_z)
            spec_res = b_q;
        else if (b_z)
            spec_res = a_q;
        else
            spec_hit = 1'b0;
    end

    assign sum_d = eff_sub ? (l_sig - m_al) : (l_sig + m_al);

    // distance from the top set bit up to the bit-13 hidden position
    always_comb begin
        lzc = 4'd0;
        for (int i = 0; i < 14; i++)
            if (sum_q[i])
                lzc = 4'(13 - i);
    end

    always_comb begin
        if (sum_q[14])
            exp_n = 7'(l_exp) + 7'sd1;
        else
            exp_n = 7'(l_exp) - 7'(lzc);
        if (exp_n >= 7'sd31)
            norm_res = {l_sign, 5'h1F, 10'h000};
        else if (exp_n <= 7'sd0)
            norm_res = 16'h0000;
        else
            norm_res = {l_sign, exp_n[4:0],
                        bus.shift_data_in[12:3]};
    end

    always_comb begin
        state_d = state;
        res_d   = result_q;
        unique case (state)
            IDLE:   if (bus.start_in) state_d = UNPACK;
            UNPACK: begin
                if (spec_hit) begin
                    state_d = DONE;
                    res_d   = spec_res;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN:  state_d = ADD;
            ADD: begin
                if (sum_d == 16'd0) begin
                    state_d = DONE;
                    res_d   = 16'h0000;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                res_d   = norm_res;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.shift_data_out   = '0;
        bus.shift_amount_out = '0;
        bus.shift_dir_out    = 1'b0;
        unique case (state)
            ALIGN: begin
                bus.shift_data_out   = WIDTH'(m_sig);
                bus.shift_amount_out = AMOUNT_WIDTH'(diff);
                bus.shift_dir_out    = 1'b1;
            end
            NORM: begin
                bus.shift_data_out = WIDTH'(sum_q);
                if (sum_q[14]) begin
                    bus.shift_amount_out = AMOUNT_WIDTH'(1);
                    bus.shift_dir_out    = 1'b1;
                end else begin
                    bus.shift_amount_out = AMOUNT_WIDTH'(lzc);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            l_sign   <= 1'b0;
            eff_sub  <= 1'b0;
            l_exp    <= '0;
            diff     <= '0;
            l_sig    <= '0;
            m_sig    <= '0;
            m_al     <= '0;
            sum_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            if (state_d == DONE)
                result_q <= res_d;
            unique case (state)
                IDLE: if (bus.start_in) begin
                    a_q <= bus.a_in;
                    b_q <= {bus.b_in[15] ^ bus.op_in,
                            bus.b_in[14:0]};
                end
                UNPACK: begin
                    eff_sub <= sa ^ sb;
                    if (a_ge) begin
                        l_sign <= sa;
                        l_exp  <= ea;
                        diff   <= ea - eb;
                        l_sig  <= {2'b00, 1'b1, fa, 3'b000};
                        m_sig  <= {2'b00, 1'b1, fb, 3'b000};
                    end else begin
                        l_sign <= sb;
                        l_exp  <= eb;
                        diff   <= eb - ea;
                        l_sig  <= {2'b00, 1'b1, fb, 3'b000};
                        m_sig  <= {2'b00, 1'b1, fa, 3'b000};
                    end
                end
                ALIGN: m_al  <= bus.shift_data_in[15:0];
                ADD:   sum_q <= sum_d;
                default: ;
            endcase
        end
    end

    assign bus.busy_out   = (state != IDLE);
    assign bus.done_out   = (state == DONE);
    assign bus.result_out = result_q;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Directed bench for fp16_add_sequencer with a behavioural shifter.
// Expected results and latencies are hand-computed binary16 values.
module tb_fp16_add_sequencer;
    localparam int W  = 16;
    localparam int AW = 8;

    logic clock_in = 1'b0;
    logic reset_in = 1'b1;

    fp16_add_sequencer_if #(.WIDTH(W), .AMOUNT_WIDTH(AW)) bus ();

    fp16_add_sequencer #(.WIDTH(W), .AMOUNT_WIDTH(AW)) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    assign bus.shift_data_in =
        (bus.shift_amount_out > AW'(W)) ? '0 :
        bus.shift_dir_out ? (bus.shift_data_out >> bus.shift_amount_out)
                          : (bus.shift_data_out << bus.shift_amount_out);

    int vectors    = 0;
    int miscompares = 0;
    int lat;
    int dones;
    logic [15:0] al_data;
    logic [7:0]  al_amt, n_amt;
    logic        al_dir, n_dir;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic op,
                          input logic glitch,
                          input logic [15:0] exp_res, input int exp_lat);
        @(negedge clock_in);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.op_in    = op;
        bus.start_in = 1'b1;
        @(posedge clock_in);
        #1;
        bus.start_in = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) chk({tag, " busy"}, 32'(bus.busy_out), 32'd1);
            if (c == 2) begin
                al_data = bus.shift_data_out;
                al_amt  = bus.shift_amount_out;
                al_dir  = bus.shift_dir_out;
                if (glitch) bus.start_in = 1'b1;
            end
            if (c == 3) bus.start_in = 1'b0;
            if (c == 4) begin
                n_amt = bus.shift_amount_out;
                n_dir = bus.shift_dir_out;
            end
            if (bus.done_out) begin
                lat = c;
                break;
            end
            @(posedge clock_in);
            #1;
        end
        bus.start_in = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, 32'(bus.result_out), 32'(exp_res));
        @(posedge clock_in);
        #1;
        chk({tag, " done_clr"}, 32'(bus.done_out), 32'd0);
        chk({tag, " idle"}, 32'(bus.busy_out), 32'd0);
        chk({tag, " hold"}, 32'(bus.result_out), 32'(exp_res));
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.op_in    = 1'b0;

        #3;
        chk("rst busy", 32'(bus.busy_out), 32'd0);
        chk("rst done", 32'(bus.done_out), 32'd0);
        chk("rst result", 32'(bus.result_out), 32'd0);
        chk("rst sdata", 32'(bus.shift_data_out), 32'd0);
        chk("rst samt", 32'(bus.shift_amount_out), 32'd0);
        chk("rst sdir", 32'(bus.shift_dir_out), 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;

        run_op("1+1", 16'h3C00, 16'h3C00, 1'b0, 1'b0, 16'h4000, 5);
        chk("1+1 align amt", 32'(al_amt), 32'd0);
        chk("1+1 align dir", 32'(al_dir), 32'd1);
        chk("1+1 align data", 32'(al_data), 32'h2000);
        chk("1+1 norm amt", 32'(n_amt), 32'd1);
        chk("1+1 norm dir", 32'(n_dir), 32'd1);

        run_op("1-1", 16'h3C00, 16'h3C00, 1'b1, 1'b0, 16'h0000, 4);

        run_op("lsb diff", 16'h3C01, 16'h3C00, 1'b1, 1'b0, 16'h1400, 5);
        chk("lsb norm amt", 32'(n_amt), 32'd10);
        chk("lsb norm dir", 32'(n_dir), 32'd0);

        run_op("align loss", 16'h3C00, 16'h0C00, 1'b0, 1'b0, 16'h3C00, 5);
        chk("loss align amt", 32'(al_amt), 32'd12);
        chk("loss align dir", 32'(al_dir), 32'd1);
        chk("loss norm amt", 32'(n_amt), 32'd0);

        run_op("subnorm", 16'h3C00, 16'h0001, 1'b0, 1'b0, 16'h3C00, 2);
        run_op("overflow", 16'h7BFF, 16'h7BFF, 1'b0, 1'b0, 16'h7C00, 5);
        run_op("inf-inf", 16'h7C00, 16'h7C00, 1'b1, 1'b0, 16'h7E00, 2);
        run_op("-inf+1", 16'hFC00, 16'h3C00, 1'b0, 1'b0, 16'hFC00, 2);
        run_op("nan", 16'h7E01, 16'h3C00, 1'b0, 1'b0, 16'h7E00, 2);
        run_op("2-1", 16'h4000, 16'h3C00, 1'b1, 1'b0, 16'h3C00, 5);
        chk("2-1 norm amt", 32'(n_amt), 32'd1);
        chk("2-1 norm dir", 32'(n_dir), 32'd0);
        run_op("1-2", 16'h3C00, 16'h4000, 1'b1, 1'b0, 16'hBC00, 5);

        // stray start during ALIGN must not launch a second operation
        run_op("glitch", 16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000, 5);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock_in);
            #1;
            if (bus.done_out) dones++;
        end
        chk("glitch extra done", 32'(dones), 32'd0);

        // back-to-back: run_op leaves us in the cycle after DONE
        run_op("b2b a", 16'h3C00, 16'h3C00, 1'b0, 1'b0, 16'h4000, 5);
        run_op("b2b b", 16'h4000, 16'h3C00, 1'b1, 1'b0, 16'h3C00, 5);

        // asynchronous reset during ADD
        @(negedge clock_in);
        bus.a_in     = 16'h3C00;
        bus.b_in     = 16'h3C00;
        bus.op_in    = 1'b0;
        bus.start_in = 1'b1;
        @(posedge clock_in);
        #1;
        bus.start_in = 1'b0;
        @(posedge clock_in);
        #1;
        @(posedge clock_in);
        #1;
        chk("pre-rst busy", 32'(bus.busy_out), 32'd1);
        #2;
        reset_in = 1'b1;
        #1;
        chk("mid-rst busy", 32'(bus.busy_out), 32'd0);
        chk("mid-rst done", 32'(bus.done_out), 32'd0);
        chk("mid-rst result", 32'(bus.result_out), 32'd0);
        chk("mid-rst sdata", 32'(bus.shift_data_out), 32'd0);
        chk("mid-rst samt", 32'(bus.shift_amount_out), 32'd0);
        chk("mid-rst sdir", 32'(bus.shift_dir_out), 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock_in);
            #1;
            if (bus.done_out) dones++;
        end
        chk("post-rst no done", 32'(dones), 32'd0);

        run_op("post-rst", 16'h3C00, 16'h3C00, 1'b0, 1'b0, 16'h4000, 5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fp16_add_sequencer.md
# fp16_add_sequencer

Multi-cycle half-precision (IEEE 754 binary16) add/subtract controller for the floating-point adder. It owns a single external combinational barrel shifter and uses it twice per operation: a right shift for exponent alignment, then a left or right shift for normalization. Operands arrive on a start pulse, and the result returns with a one-cycle done pulse. The block handles specials, flushes subnormals to zero and truncates.

## Interface
- WIDTH, 16, shifter datapath width; fixed at 16 for binary16.
- AMOUNT_WIDTH, 8, shifter amount width.
- clock_in  input  1  single clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  16  operand A, binary16.
- b_in  input  16  operand B, binary16.
- op_in  input  1  0 = A+B, 1 = A−B.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse; result_out is valid in that cycle.
- result_out  output  16  last result; holds until the next done.
- shift_data_out  output  WIDTH  data to the shifter.
- shift_amount_out  output  AMOUNT_WIDTH  shift amount to the shifter.
- shift_dir_out  output  1  1 = right, 0 = left.
- shift_data_in  input  WIDTH  shifter result; combinational, same cycle.

## Operation
- **Shifter model:** shift_data_in returns the shifted value. Any amount greater than WIDTH returns 0.
- **Significand format:** S = {hidden, frac[9:0]}, placed in 16 bits as {2'b00, S, 3'b000}. The leading 1 sits at bit 13.
- **IDLE:** when start_in=1, register a, b and op. If op=1, B's sign is inverted. Go to UNPACK.
- **UNPACK:**
  - Subnormal input (exp=0) → treated as ±0.
  - Any NaN → result 16'h7E00.
  - Inf with inf of opposite effective sign → 16'h7E00.
  - Any other inf → that inf.
  - Either operand zero → the other operand, with effective sign applied. Both zero → 16'h0000.
  - Each special case goes to DONE.
  - Otherwise, swap so that L ≥ M in magnitude (compare exponent, then fraction). diff = expL − expM. Go to ALIGN.
- **ALIGN:** drive shift_data_out = M's padded significand, amount = diff, dir = 1. Register shift_data_in as the aligned M. Go to ADD.
- **ADD:**
  - Same effective signs: sum = L + aligned M.
  - Otherwise: sum = L − aligned M, which never goes negative.
  - sum == 0 → result 16'h0000, go to DONE.
  - Otherwise, go to NORM.
- **NORM:**
  - If sum[14]=1: dir=1, amount=1, exp = expL+1.
  - Else: dir=0, amount = lzc, where lzc = number of positions from the top set bit up to bit 13. exp = expL − lzc.
  - The normalized value has its leading 1 at bit 13. frac = bits[12:3]; lower bits are truncated.
  - exp ≥ 31 → ±inf (sign of L).
  - exp ≤ 0 → 16'h0000.
  - Otherwise pack {signL, exp[4:0], frac}. Go to DONE.
- **DONE:** done_out=1, result_out updates. Go to IDLE.
- **Shifter outputs outside ALIGN/NORM:** data=0, amount=0, dir=0.
- **start_in while busy:** ignored; no queueing.
- **Reset:**
  - Reset outputs: state=IDLE, busy_out=0, done_out=0, result_out=16'h0000, and all shift outputs 0.
  - Reset mid-operation aborts the operation: no done pulse, and result_out is cleared.

## Timing
- start_in is sampled at edge k (cycle k). Cycle k+1 is the first cycle after that edge.
- Normal path: UNPACK k+1, ALIGN k+2, ADD k+3, NORM k+4, DONE k+5. done_out is high in cycle k+5.
- Zero-sum path: done_out high in cycle k+4.
- Special-case path: done_out high in cycle k+2.
- busy_out is high from cycle k+1 through the DONE cycle inclusive.
- A new start_in is accepted in the cycle after DONE.
- result_out changes only on the edge that enters DONE, so it is stable during the done_out cycle.

## Test plan
- **1.0 + 1.0:** 0x3C00 + 0x3C00, op=0 → result 0x4000, done_out at k+5. Check the NORM shift: right by 1.
- **Exact cancellation, then left normalization:**
  - 0x3C00 − 0x3C00 → 0x0000 at k+4.
  - 0x3C01 − 0x3C00 → 0x1400 at k+5, with shift_amount_out=10 and dir=0 in NORM.
- **Alignment loss and subnormal flush:**
  - 0x3C00 + 0x0C00 (diff 12) → 0x3C00.
  - 0x3C00 + 0x0001 (subnormal) → 0x3C00, via the special path at k+2.
- **Overflow and specials:**
  - 0x7BFF + 0x7BFF → 0x7C00.
  - 0x7C00 − 0x7C00 → 0x7E00 at k+2.
  - 0xFC00 + 0x3C00 → 0xFC00.
- **Handshake:**
  - Pulse start_in during ALIGN → ignored, exactly one done.
  - Back-to-back start_in in the cycle after DONE → accepted.
- **Reset:** assert reset_in asynchronously during ADD → all outputs 0 immediately, no done pulse. The next start_in completes normally.
